ssd_scan_decoder: RTL and testbench

//   Receive side of the seven-segment display path. Samples a multiplexed SSD bus:
//   8 segment lines ({DP, g..a}) plus one anode line per digit. Decodes each stable

---
 rtl/ssd_scan_decoder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ssd_scan_decoder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_decoder.sv
// ----------------------------------------------------------------------------
// ssd_scan_decoder
//   Receive side of a multiplexed seven-segment display bus. The segment and
//   anode lines are resynchronised and normalised to active-high. A digit is
//   accepted once its {seg, an} sample has been stable for STABLE_CYCLES
//   samples. Each accepted digit is decoded back to a hex nibble plus DP flag
//   and stored in the slot given by its one-hot anode. When every slot has been
//   seen, the assembled frame is published with a one-cycle valid pulse.
//
// Ports
//   clk           in   1          system clock, rising edge
//   rst_n         in   1          asynchronous reset, active low
//   ssd_seg       in   8          [7]=DP, [6:0]=g..a, asynchronous to clk
//   ssd_an        in   DIGITS     digit select, bit i = nibble slot i
//   frame_digits  out  4*DIGITS   digit i at [4i+3:4i], held between frames
//   frame_dp      out  DIGITS     DP flag per digit, held between frames
//   frame_valid   out  1          one-cycle pulse when frame_* update
//   frame_err     out  1          some slot of the published frame was undecodable
//   scan_lost     out  1          no digit accepted for TIMEOUT_CYCLES cycles
// ----------------------------------------------------------------------------
module ssd_scan_decoder #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            ssd_seg,
    input  logic [DIGITS-1:0]     ssd_an,
    output logic [4*DIGITS-1:0]   frame_digits,
    output logic [DIGITS-1:0]     frame_dp,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  scan_lost
);

    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    // Raw-line levels that correspond to "not lit" / "not selected".
    localparam logic [7:0]        SEG_INV_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_INV_MASK  = {DIGITS{AN_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_ONE       = DIGITS'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT   = IDLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    // Returns {undecodable, nibble}; undecodable patterns map to nibble 0.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h3F:   res = 5'h00;
            7'h06:   res = 5'h01;
            7'h5B:   res = 5'h02;
            7'h4F:   res = 5'h03;
            7'h66:   res = 5'h04;
            7'h6D:   res = 5'h05;
            7'h7D:   res = 5'h06;
            7'h07:   res = 5'h07;
            7'h7F:   res = 5'h08;
            7'h6F:   res = 5'h09;
            7'h77:   res = 5'h0A;
            7'h7C:   res = 5'h0B;
            7'h39:   res = 5'h0C;
            7'h5E:   res = 5'h0D;
            7'h79:   res = 5'h0E;
            7'h71:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

    logic [7:0]          seg_meta_r, seg_sync_r, prev_seg_r;
    logic [DIGITS-1:0]   an_meta_r, an_sync_r, prev_an_r;
    logic [7:0]          seg_s;
    logic [DIGITS-1:0]   an_s;
    logic                onehot_s, same_s, accept_s;
    logic [4:0]          dec_s;
    state_t              state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [IDLE_W-1:0]   idle_r, idle_nxt_s;
    logic                timeout_s, complete_s;
    logic [DIGITS-1:0]   seen_r, seen_nxt_s, err_r, err_nxt_s;
    logic [DIGITS-1:0]   seen_base_s, err_base_s;
    logic [4*DIGITS-1:0] shadow_r;
    logic [DIGITS-1:0]   dp_shadow_r;
    logic [4*DIGITS-1:0] frame_digits_r;
    logic [DIGITS-1:0]   frame_dp_r;
    logic                frame_valid_r, frame_err_r, scan_lost_r;

    // Two-flop synchroniser; flops reset to the raw inactive level so the
    // normalised sample is all zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_meta_r <= SEG_INV_MASK;
            seg_sync_r <= SEG_INV_MASK;
            an_meta_r  <= AN_INV_MASK;
            an_sync_r  <= AN_INV_MASK;
        end else begin
            seg_meta_r <= ssd_seg;
            seg_sync_r <= seg_meta_r;
            an_meta_r  <= ssd_an;
            an_sync_r  <= an_meta_r;
        end
    end

    assign seg_s    = seg_sync_r ^ SEG_INV_MASK;
    assign an_s     = an_sync_r ^ AN_INV_MASK;
    assign onehot_s = (an_s != '0) && ((an_s & (an_s - AN_ONE)) == '0);
    assign same_s   = (seg_s == prev_seg_r) && (an_s == prev_an_r);
    assign dec_s    = decode_seg(seg_s[6:0]);

    // Previous normalised sample, used for the stability comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_seg_r <= 8'h00;
            prev_an_r  <= '0;
        end else begin
            prev_seg_r <= seg_s;
            prev_an_r  <= an_s;
        end
    end

    // Stability FSM next-state: cnt counts consecutive identical samples,
    // the sample that first shows a new pattern counting as 1.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (onehot_s) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = CNT_W'(1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (!same_s) begin
                    if (onehot_s) begin
                        cnt_nxt_s = CNT_W'(1);
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_W'(0);
                    end
                end else if (cnt_r == CNT_LAST) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_HELD: begin
                // A long dwell stays here, so one pattern yields one accept.
                if (!same_s) begin
                    if (onehot_s) begin
                        state_nxt_s = ST_SETTLE;
                        cnt_nxt_s   = CNT_W'(1);
                    end else begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_W'(0);
                    end
                end else begin
                    state_nxt_s = ST_HELD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_W'(0);
            end
        endcase
    end

    // Stability FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Frame bookkeeping: seen/err masks restart after a published frame or a
    // timeout; an accept in that same cycle belongs to the new frame.
    always_comb begin
        complete_s = &seen_r;
        if (accept_s) begin
            idle_nxt_s = '0;
        end else if (idle_r == IDLE_LIMIT) begin
            idle_nxt_s = idle_r;
        end else begin
            idle_nxt_s = idle_r + IDLE_W'(1);
        end
        timeout_s = !accept_s && (idle_nxt_s == IDLE_LIMIT);
        if (complete_s || timeout_s) begin
            seen_base_s = '0;
            err_base_s  = '0;
        end else begin
            seen_base_s = seen_r;
            err_base_s  = err_r;
        end
        if (accept_s) begin
            seen_nxt_s = seen_base_s | an_s;
            err_nxt_s  = (err_base_s & ~an_s) | (an_s & {DIGITS{dec_s[4]}});
        end else begin
            seen_nxt_s = seen_base_s;
            err_nxt_s  = err_base_s;
        end
    end

    // Masks, idle counter, and the scan-lost level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_r      <= '0;
            err_r       <= '0;
            idle_r      <= '0;
            scan_lost_r <= 1'b0;
        end else begin
            seen_r <= seen_nxt_s;
            err_r  <= err_nxt_s;
            idle_r <= idle_nxt_s;
            if (accept_s) begin
                scan_lost_r <= 1'b0;
            end else if (timeout_s) begin
                scan_lost_r <= 1'b1;
            end else begin
                scan_lost_r <= scan_lost_r;
            end
        end
    end

    // Shadow slots written by accepts; undecodable patterns store nibble 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r    <= '0;
            dp_shadow_r <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (accept_s && an_s[i]) begin
                    shadow_r[4*i +: 4] <= dec_s[3:0];
                    dp_shadow_r[i]     <= seg_s[7];
                end
            end
        end
    end

    // Published frame, loaded the cycle after the last slot was seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_digits_r <= '0;
            frame_dp_r     <= '0;
            frame_err_r    <= 1'b0;
            frame_valid_r  <= 1'b0;
        end else if (complete_s) begin
            frame_digits_r <= shadow_r;
            frame_dp_r     <= dp_shadow_r;
            frame_err_r    <= |err_r;
            frame_valid_r  <= 1'b1;
        end else begin
            frame_valid_r  <= 1'b0;
        end
    end

    assign frame_digits = frame_digits_r;
    assign frame_dp     = frame_dp_r;
    assign frame_valid  = frame_valid_r;
    assign frame_err    = frame_err_r;
    assign scan_lost    = scan_lost_r;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Testbench for ssd_scan_decoder. Instance a uses the default polarities;
// instance b is built with inverted polarities and fed the inverted pins.
module tb_ssd_scan_decoder;

    localparam int TMO = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ssd_seg;
    logic [3:0]  ssd_an;
    logic [7:0]  seg_b;
    logic [3:0]  an_b;
    logic [15:0] digits_a, digits_b;
    logic [3:0]  dp_a, dp_b;
    logic        fv_a, fv_b, err_a, err_b, lost_a, lost_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frames_a = 0;
    int frames_b = 0;
    int fv_cyc_a = 0;
    int fv_cyc_b = 0;

    always #5 clk = ~clk;

    assign seg_b = ~ssd_seg;
    assign an_b  = ~ssd_an;

    ssd_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(16), .TIMEOUT_CYCLES(TMO),
                       .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ssd_seg(ssd_seg), .ssd_an(ssd_an),
        .frame_digits(digits_a), .frame_dp(dp_a), .frame_valid(fv_a),
        .frame_err(err_a), .scan_lost(lost_a));

    ssd_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(16), .TIMEOUT_CYCLES(TMO),
                       .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ssd_seg(seg_b), .ssd_an(an_b),
        .frame_digits(digits_b), .frame_dp(dp_b), .frame_valid(fv_b),
        .frame_err(err_b), .scan_lost(lost_b));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fv_a) begin
            frames_a <= frames_a + 1;
            fv_cyc_a <= cyc;
        end
        if (fv_b) begin
            frames_b <= frames_b + 1;
            fv_cyc_b <= cyc;
        end
    end

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a raw pattern with a logical (active-high) anode mask.
    task automatic drive_raw(input logic [7:0] seg, input logic [3:0] an_l, input int n);
        ssd_seg = seg;
        ssd_an  = ~an_l;
        wait_cyc(n);
    endtask

    task automatic dwell(input int idx, input logic [3:0] nib, input logic dp,
                         input int n, output int dcyc);
        logic [3:0] oh;
        oh      = 4'b0001 << idx;
        ssd_seg = {dp, seg_code(nib)};
        ssd_an  = ~oh;
        dcyc    = cyc;
        wait_cyc(n);
    endtask

    task automatic blank(input int n);
        drive_raw(8'h00, 4'b0000, n);
    endtask

    task automatic scan_1a3f(output int d3cyc);
        int d;
        dwell(0, 4'h1, 1'b0, 40, d);
        dwell(1, 4'hA, 1'b0, 40, d);
        dwell(2, 4'h3, 1'b1, 40, d);
        dwell(3, 4'hF, 1'b0, 40, d3cyc);
        blank(10);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ssd_seg = 8'h00;
        ssd_an  = 4'hF;
        #2;
        n_checks++;
        if ({digits_a, dp_a, fv_a, err_a, lost_a} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {digits_a, dp_a, fv_a, err_a, lost_a});
        end
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_scan();
        int f0, d3;
        f0 = frames_a;
        scan_1a3f(d3);
        n_checks++;
        if (frames_a !== f0 + 1) begin n_fail++; $display("FAIL scan_count: got %0d expected %0d", frames_a - f0, 1); end
        n_checks++;
        if (fv_cyc_a - d3 !== 19) begin n_fail++; $display("FAIL scan_latency: got %0d expected 19", fv_cyc_a - d3); end
        n_checks++;
        if (digits_a !== 16'hF3A1) begin n_fail++; $display("FAIL scan_digits: got %h expected F3A1", digits_a); end
        n_checks++;
        if (dp_a !== 4'b0100) begin n_fail++; $display("FAIL scan_dp: got %b expected 0100", dp_a); end
        n_checks++;
        if (err_a !== 1'b0) begin n_fail++; $display("FAIL scan_err: got %b expected 0", err_a); end
    endtask

    task automatic test_reset_mid();
        int f0, d;
        dwell(0, 4'h7, 1'b0, 40, d);
        dwell(1, 4'h8, 1'b0, 40, d);
        dwell(2, 4'h9, 1'b0, 40, d);
        dwell(3, 4'h5, 1'b0, 10, d);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({digits_a, dp_a, fv_a, err_a, lost_a} !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %h expected 0", {digits_a, dp_a, fv_a, err_a, lost_a});
        end
        wait_cyc(2);
        rst_n = 1'b1;
        f0 = frames_a;
        wait_cyc(40);
        blank(20);
        n_checks++;
        if (frames_a !== f0) begin n_fail++; $display("FAIL reset_partial: got %0d frames expected 0", frames_a - f0); end
        dwell(0, 4'h7, 1'b0, 40, d);
        dwell(1, 4'h8, 1'b0, 40, d);
        dwell(2, 4'h9, 1'b0, 40, d);
        blank(20);
        n_checks++;
        if (frames_a !== f0 + 1 || digits_a !== 16'h5987) begin
            n_fail++;
            $display("FAIL reset_refill: got %0d frames digits %h expected 1 frame 5987", frames_a - f0, digits_a);
        end
    endtask

    task automatic test_glitch();
        int f0, d;
        f0 = frames_a;
        dwell(1, 4'h6, 1'b0, 40, d);
        dwell(2, 4'h7, 1'b0, 40, d);
        dwell(3, 4'h8, 1'b0, 40, d);
        dwell(0, 4'h2, 1'b0, 15, d);
        blank(30);
        n_checks++;
        if (frames_a !== f0) begin n_fail++; $display("FAIL glitch_short: got %0d frames expected 0", frames_a - f0); end
        dwell(0, 4'h4, 1'b0, 16, d);
        blank(30);
        n_checks++;
        if (frames_a !== f0 + 1 || digits_a !== 16'h8764) begin
            n_fail++;
            $display("FAIL glitch_exact: got %0d frames digits %h expected 1 frame 8764", frames_a - f0, digits_a);
        end
        dwell(1, 4'h9, 1'b0, 40, d);
        dwell(2, 4'hB, 1'b0, 40, d);
        dwell(3, 4'hC, 1'b0, 40, d);
        dwell(0, 4'hD, 1'b0, 1000, d);
        blank(10);
        n_checks++;
        if (frames_a !== f0 + 2 || digits_a !== 16'hCB9D) begin
            n_fail++;
            $display("FAIL long_dwell_frame: got %0d frames digits %h expected 2 frames CB9D", frames_a - f0, digits_a);
        end
        dwell(1, 4'h9, 1'b0, 40, d);
        dwell(2, 4'hB, 1'b0, 40, d);
        dwell(3, 4'hC, 1'b0, 40, d);
        blank(30);
        n_checks++;
        if (frames_a !== f0 + 2) begin n_fail++; $display("FAIL long_dwell_single: got %0d frames expected 2", frames_a - f0); end
        dwell(0, 4'hE, 1'b0, 40, d);
        blank(20);
        n_checks++;
        if (frames_a !== f0 + 3 || digits_a !== 16'hCB9E) begin
            n_fail++;
            $display("FAIL long_dwell_next: got %0d frames digits %h expected 3 frames CB9E", frames_a - f0, digits_a);
        end
    endtask

    task automatic test_bad_pattern();
        int f0, d;
        f0 = frames_a;
        dwell(0, 4'h1, 1'b0, 40, d);
        drive_raw(8'h00, 4'b0010, 40);
        dwell(2, 4'h3, 1'b0, 40, d);
        dwell(3, 4'hF, 1'b0, 40, d);
        blank(10);
        n_checks++;
        if (frames_a !== f0 + 1 || err_a !== 1'b1 || digits_a !== 16'hF301) begin
            n_fail++;
            $display("FAIL bad_frame: got %0d frames err %b digits %h expected 1 frame err 1 F301", frames_a - f0, err_a, digits_a);
        end
        scan_1a3f(d);
        n_checks++;
        if (frames_a !== f0 + 2 || err_a !== 1'b0 || digits_a !== 16'hF3A1) begin
            n_fail++;
            $display("FAIL bad_recover: got %0d frames err %b digits %h expected 2 frames err 0 F3A1", frames_a - f0, err_a, digits_a);
        end
    endtask

    task automatic test_multi_hot_timeout();
        int f0, d;
        f0 = frames_a;
        dwell(1, 4'h1, 1'b0, 40, d);
        dwell(2, 4'h2, 1'b0, 40, d);
        dwell(3, 4'h3, 1'b0, 40, d);
        drive_raw({1'b0, seg_code(4'h8)}, 4'b0011, 40);
        drive_raw({1'b0, seg_code(4'h8)}, 4'b0000, 40);
        n_checks++;
        if (frames_a !== f0 || lost_a !== 1'b0) begin
            n_fail++;
            $display("FAIL multi_hot: got %0d frames lost %b expected 0 frames lost 0", frames_a - f0, lost_a);
        end
        wait_cyc(TMO);
        n_checks++;
        if (lost_a !== 1'b1 || frames_a !== f0) begin
            n_fail++;
            $display("FAIL lost_idle: got lost %b frames %0d expected lost 1 frames 0", lost_a, frames_a - f0);
        end
        dwell(0, 4'h4, 1'b0, 40, d);
        dwell(1, 4'h5, 1'b0, 40, d);
        dwell(2, 4'h6, 1'b0, 40, d);
        blank(TMO + 17 - 40);
        n_checks++;
        if (lost_a !== 1'b0) begin n_fail++; $display("FAIL lost_early: got %b expected 0", lost_a); end
        wait_cyc(1);
        n_checks++;
        if (lost_a !== 1'b1) begin n_fail++; $display("FAIL lost_exact: got %b expected 1", lost_a); end
        n_checks++;
        if (frames_a !== f0 || digits_a !== 16'hF3A1) begin
            n_fail++;
            $display("FAIL lost_hold: got %0d frames digits %h expected 0 frames F3A1", frames_a - f0, digits_a);
        end
        dwell(0, 4'h7, 1'b0, 17, d);
        n_checks++;
        if (lost_a !== 1'b1) begin n_fail++; $display("FAIL lost_before_accept: got %b expected 1", lost_a); end
        wait_cyc(1);
        n_checks++;
        if (lost_a !== 1'b0) begin n_fail++; $display("FAIL lost_clear: got %b expected 0", lost_a); end
        wait_cyc(22);
        dwell(1, 4'h8, 1'b0, 40, d);
        dwell(2, 4'h9, 1'b0, 40, d);
        dwell(3, 4'hA, 1'b0, 40, d);
        blank(10);
        n_checks++;
        if (frames_a !== f0 + 1 || digits_a !== 16'hA987) begin
            n_fail++;
            $display("FAIL lost_resume: got %0d frames digits %h expected 1 frame A987", frames_a - f0, digits_a);
        end
    endtask

    task automatic test_polarity();
        int f0, d3;
        f0 = frames_b;
        scan_1a3f(d3);
        n_checks++;
        if (frames_b !== f0 + 1) begin n_fail++; $display("FAIL pol_count: got %0d expected 1", frames_b - f0); end
        n_checks++;
        if (fv_cyc_b - d3 !== 19) begin n_fail++; $display("FAIL pol_latency: got %0d expected 19", fv_cyc_b - d3); end
        n_checks++;
        if (digits_b !== 16'hF3A1 || dp_b !== 4'b0100 || err_b !== 1'b0 || lost_b !== 1'b0) begin
            n_fail++;
            $display("FAIL pol_frame: got digits %h dp %b err %b lost %b expected F3A1 0100 0 0", digits_b, dp_b, err_b, lost_b);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_reset_mid();
        test_glitch();
        test_bad_pattern();
        test_multi_hot_timeout();
        test_polarity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
